// File: rtl/audio_i2s_tx_fifo.sv
// audio_i2s_tx_fifo
//   I2S / left-justified audio DAC serialiser fed from a stereo frame FIFO,
//   with a built-in square-wave test tone.
// Ports
//   iCLK, iRST      codec control clock, async active-high reset
//   iEnable         run serialiser (FIFO accepts regardless)
//   iMode           0 I2S, 1 LJ, 2 test tone (I2S framing), 3 acts as 0
//   iData/iValid    {left,right} frame push; oReady = room available
//   oFifoLevel      frames stored
//   oUnderrun       1-cycle pulse when a frame boundary finds the FIFO empty
//   oAUD_BCK/LRCK/DATA  codec pins
module audio_i2s_tx_fifo #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int BCLK_DIV   = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int TONE_HALF  = 24
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iEnable,
  input  logic [1:0]                    iMode,
  input  logic [2*SAMPLE_W-1:0]         iData,
  input  logic                          iValid,
  output logic                          oReady,
  output logic [$clog2(FIFO_DEPTH):0]   oFifoLevel,
  output logic                          oUnderrun,
  output logic                          oAUD_BCK,
  output logic                          oAUD_LRCK,
  output logic                          oAUD_DATA
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2*SLOT_W);
  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [DW-1:0] DIV_MAX   = DW'(BCLK_DIV-1);
  localparam logic [BW-1:0] BIT_MAX   = BW'(2*SLOT_W-1);
  localparam logic [BW-1:0] SLOT_P    = BW'(SLOT_W);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF-1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [SAMPLE_W-1:0] TONE_POS = {2'b01, {(SAMPLE_W-2){1'b0}}};
  localparam logic [SAMPLE_W-1:0] TONE_NEG = {2'b11, {(SAMPLE_W-2){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  bck_q, bck_d, lrck_q, lrck_d, data_q, data_d;
  logic                  dly_q, dly_d;       // I2S one-BCK delay of the LJ stream
  logic [2*SAMPLE_W-1:0] frame_q, frame_d;
  logic [1:0]            mode_q, mode_d;
  logic                  tone_neg_q, tone_neg_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  und_q, und_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ready_q, ready_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2*SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic                  push, pop, lj_w;

  // Slot bit k carries sample bit SAMPLE_W-1-k; shifting left by k past the
  // sample width yields the zero padding for free.
  function automatic logic lj_bit(input logic [2*SAMPLE_W-1:0] f, input logic [BW-1:0] p);
    logic [SAMPLE_W-1:0] s;
    int k;
    s = (p >= SLOT_P) ? f[SAMPLE_W-1:0] : f[2*SAMPLE_W-1:SAMPLE_W];
    k = (p >= SLOT_P) ? int'(p) - SLOT_W : int'(p);
    s = s << k;
    return s[SAMPLE_W-1];
  endfunction

  assign push = iValid & ready_q;

  always_comb begin
    state_d = state_q;  div_d = div_q;   bit_d = bit_q;
    bck_d = bck_q;      lrck_d = lrck_q; data_d = data_q;  dly_d = dly_q;
    frame_d = frame_q;  mode_d = mode_q;
    tone_neg_d = tone_neg_q;  tcnt_d = tcnt_q;
    und_d = 1'b0;  pop = 1'b0;  lj_w = 1'b0;
    case (state_q)
      IDLE: if (iEnable) state_d = RUN;
      RUN: begin
        if (!iEnable) begin
          // abandon the frame in flight; pins idle from the next cycle
          state_d = IDLE;  div_d = '0;  bit_d = BIT_MAX;
          bck_d = 1'b0;  lrck_d = 1'b0;  data_d = 1'b0;  dly_d = 1'b0;
        end else if (div_q == DIV_MAX) begin
          div_d = '0;
          bck_d = ~bck_q;
          if (bck_q) begin
            // falling BCK edge
            bit_d = (bit_q == BIT_MAX) ? '0 : bit_q + 1'b1;
            if (bit_d == '0) begin
              mode_d = (iMode == 2'd3) ? 2'd0 : iMode;
              if (mode_d == 2'd2) begin
                frame_d = tone_neg_q ? {TONE_NEG, TONE_NEG} : {TONE_POS, TONE_POS};
                if (tcnt_q == TONE_LAST) begin
                  tcnt_d = '0;
                  tone_neg_d = ~tone_neg_q;
                end else begin
                  tcnt_d = tcnt_q + 1'b1;
                end
              end else if (level_q != '0) begin
                pop = 1'b1;
                frame_d = mem_q[rd_ptr_q];
              end else begin
                frame_d = '0;
                und_d = 1'b1;
              end
            end
            lj_w   = lj_bit(frame_d, bit_d);
            lrck_d = (bit_d >= SLOT_P);
            data_d = (mode_d == 2'd1) ? lj_w : dly_q;
            dly_d  = lj_w;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; pop only ever sees the pre-push level
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    ready_d  = (level_d < DEPTH_L);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;  div_q <= '0;  bit_q <= BIT_MAX;
      bck_q <= 1'b0;  lrck_q <= 1'b0;  data_q <= 1'b0;  dly_q <= 1'b0;
      frame_q <= '0;  mode_q <= '0;  tone_neg_q <= 1'b0;  tcnt_q <= '0;
      und_q <= 1'b0;  level_q <= '0;  ready_q <= 1'b0;
      wr_ptr_q <= '0;  rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;  div_q <= div_d;  bit_q <= bit_d;
      bck_q <= bck_d;  lrck_q <= lrck_d;  data_q <= data_d;  dly_q <= dly_d;
      frame_q <= frame_d;  mode_q <= mode_d;  tone_neg_q <= tone_neg_d;  tcnt_q <= tcnt_d;
      und_q <= und_d;  level_q <= level_d;  ready_q <= ready_d;
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) mem_q[wr_ptr_q] <= iData;
  end

  assign oReady     = ready_q;
  assign oFifoLevel = level_q;
  assign oUnderrun  = und_q;
  assign oAUD_BCK   = bck_q;
  assign oAUD_LRCK  = lrck_q;
  assign oAUD_DATA  = data_q;
endmodule
